tbird_light_seq: RTL and testbench

//  Thunderbird tail-light sequencer. Consumes the one-cycle slow-tick strobe from the clock

---
 rtl/tbird_pkg.sv | 62 ++++++
 rtl/tbird_light_seq_sync_2ff.sv | 26 ++
 rtl/tbird_light_seq.sv | 100 ++++++++++
 tb/tb_tbird_light_seq.sv | 135 +++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
// Shared types for the Thunderbird tail-light sequencer: state codes, lamp patterns, request decode.
package tbird_pkg;

    localparam int unsigned LAMP_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_R1   = 3'd4,
        ST_R2   = 3'd5,
        ST_R3   = 3'd6,
        ST_HZ   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_LEFT  = 2'd1,
        REQ_RIGHT = 2'd2,
        REQ_HAZ   = 2'd3
    } req_e;

    localparam logic [LAMP_W-1:0] LAMP_OFF = 3'b000;
    localparam logic [LAMP_W-1:0] LAMP_1   = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_2   = 3'b011;
    localparam logic [LAMP_W-1:0] LAMP_3   = 3'b111;

    typedef struct packed {
        logic [LAMP_W-1:0] left;
        logic [LAMP_W-1:0] right;
    } lamps_t;

    // Both turn switches together are treated as a hazard request.
    function automatic req_e decode_req(input logic s_l, input logic s_r, input logic s_h);
        if (s_h || (s_l && s_r)) return REQ_HAZ;
        else if (s_l)            return REQ_LEFT;
        else if (s_r)            return REQ_RIGHT;
        else                     return REQ_NONE;
    endfunction

    function automatic lamps_t lamp_code(input state_e st);
        lamps_t l;
        l.left  = LAMP_OFF;
        l.right = LAMP_OFF;
        case (st)
            ST_L1:   l.left = LAMP_1;
            ST_L2:   l.left = LAMP_2;
            ST_L3:   l.left = LAMP_3;
            ST_R1:   l.right = LAMP_1;
            ST_R2:   l.right = LAMP_2;
            ST_R3:   l.right = LAMP_3;
            ST_HZ: begin
                l.left  = LAMP_3;
                l.right = LAMP_3;
            end
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/tbird_light_seq_sync_2ff.sv
// W-bit two-flop synchroniser for asynchronous switch inputs, async active-low reset to 0.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tbird_light_seq.sv
// Thunderbird tail-light sequencer: animates three lamps per side for left, right and hazard,
// advancing one lamp state every STEP_TICKS divider ticks.
module tbird_light_seq
    import tbird_pkg::*;
#(
    parameter int unsigned STEP_TICKS = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              left_sw,
    input  logic              right_sw,
    input  logic              haz_sw,
    output logic [LAMP_W-1:0] left_lamps,
    output logic [LAMP_W-1:0] right_lamps,
    output logic              step,
    output logic              busy
);

    localparam int unsigned      CNT_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);

    logic [2:0]       w_sync;
    req_e             w_req;
    logic             w_step;
    logic [CNT_W-1:0] w_cnt_nxt;
    state_e           w_state_nxt;
    lamps_t           w_lamps_nxt;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;

    sync_2ff #(
        .W (3)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     ({haz_sw, right_sw, left_sw}),
        .o_q     (w_sync)
    );

    // Step counter: idle holds it at zero, otherwise it counts ticks and wraps on a step.
    always_comb begin
        w_req     = decode_req(w_sync[0], w_sync[1], w_sync[2]);
        w_step    = 1'b0;
        w_cnt_nxt = r_cnt;
        if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
        end else if (tick) begin
            if (r_cnt == CNT_LAST) begin
                w_cnt_nxt = '0;
                w_step    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Next-state: idle reacts every clk, animation states advance only on a step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                case (w_req)
                    REQ_HAZ:   w_state_nxt = ST_HZ;
                    REQ_LEFT:  w_state_nxt = ST_L1;
                    REQ_RIGHT: w_state_nxt = ST_R1;
                    default:   w_state_nxt = ST_IDLE;
                endcase
            end
            ST_L1: if (w_step) w_state_nxt = (w_req == REQ_HAZ) ? ST_IDLE : ST_L2;
            ST_L2: if (w_step) w_state_nxt = (w_req == REQ_HAZ) ? ST_IDLE : ST_L3;
            ST_R1: if (w_step) w_state_nxt = (w_req == REQ_HAZ) ? ST_IDLE : ST_R2;
            ST_R2: if (w_step) w_state_nxt = (w_req == REQ_HAZ) ? ST_IDLE : ST_R3;
            ST_L3, ST_R3, ST_HZ: if (w_step) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_lamps_nxt = lamp_code(w_state_nxt);
    end

    // Lamps and busy are taken from next-state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            step        <= 1'b0;
            busy        <= 1'b0;
            left_lamps  <= LAMP_OFF;
            right_lamps <= LAMP_OFF;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            step        <= w_step;
            busy        <= (w_state_nxt != ST_IDLE);
            left_lamps  <= w_lamps_nxt.left;
            right_lamps <= w_lamps_nxt.right;
        end
    end

endmodule

// File: tb/tb_tbird_light_seq.sv
// Directed bench for tbird_light_seq with STEP_TICKS=2 and a tick on every 4th clk edge.
module tb_tbird_light_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       left_sw;
    logic       right_sw;
    logic       haz_sw;
    logic [2:0] left_lamps;
    logic [2:0] right_lamps;
    logic       step;
    logic       busy;

    int n_pass = 0;
    int n_chk  = 0;
    int n      = 0;

    always #5 clk = ~clk;

    tbird_light_seq #(
        .STEP_TICKS (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .left_sw     (left_sw),
        .right_sw    (right_sw),
        .haz_sw      (haz_sw),
        .left_lamps  (left_lamps),
        .right_lamps (right_lamps),
        .step        (step),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Compares {left_lamps, right_lamps, step, busy}.
    task automatic chk_o(input string tag, input logic [2:0] l, input logic [2:0] r,
                         input logic s, input logic b);
        chk(tag, {left_lamps, right_lamps, step, busy}, {l, r, s, b});
    endtask

    // One clk edge numbered n; tick is high for edges where n is a multiple of 4.
    task automatic cyc();
        n++;
        tick = (n % 4 == 0);
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic cycles(input int k);
        repeat (k) cyc();
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
        #12;
        chk_o("reset_state", 3'b000, 3'b000, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1; n = 0;

        // Left held: L1 two edges after sync, steps every 8 clks, repeats.
        left_sw = 1'b1;
        cycles(2); chk_o("left_n2_sync", 3'b000, 3'b000, 1'b0, 1'b0);
        cyc();     chk_o("left_n3_L1",   3'b001, 3'b000, 1'b0, 1'b1);
        cycles(4); chk_o("left_n7_L1",   3'b001, 3'b000, 1'b0, 1'b1);
        cyc();     chk_o("left_n8_L2",   3'b011, 3'b000, 1'b1, 1'b1);
        cyc();     chk_o("left_n9_L2",   3'b011, 3'b000, 1'b0, 1'b1);
        cycles(7); chk_o("left_n16_L3",  3'b111, 3'b000, 1'b1, 1'b1);
        cycles(8); chk_o("left_n24_idle",3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("left_n25_L1",  3'b001, 3'b000, 1'b0, 1'b1);
        cycles(7); chk_o("left_n32_L2",  3'b011, 3'b000, 1'b1, 1'b1);
        cyc();     chk_o("left_n33_L2",  3'b011, 3'b000, 1'b0, 1'b1);

        // Reset mid-L2 blanks everything before the next edge and holds.
        #2 reset = 1'b0;
        #1 chk_o("reset_async", 3'b000, 3'b000, 1'b0, 1'b0);
        left_sw = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_o("reset_held", 3'b000, 3'b000, 1'b0, 1'b0);
        chk("reset_cnt", 8'(dut.r_cnt), 8'd0);
        reset = 1'b1; n = 0;

        // Right released during R1: sequence still completes, then idles.
        right_sw = 1'b1;
        cycles(3); chk_o("right_n3_R1",   3'b000, 3'b001, 1'b0, 1'b1);
        right_sw = 1'b0;
        cycles(5); chk_o("right_n8_R2",   3'b000, 3'b011, 1'b1, 1'b1);
        cycles(8); chk_o("right_n16_R3",  3'b000, 3'b111, 1'b1, 1'b1);
        cycles(8); chk_o("right_n24_idle",3'b000, 3'b000, 1'b1, 1'b0);
        cycles(8); chk_o("right_n32_idle",3'b000, 3'b000, 1'b0, 1'b0);

        // Left+right decodes as hazard: flash with a one-clk off phase.
        left_sw = 1'b1; right_sw = 1'b1;
        cycles(3); chk_o("lr_n35_HZ",   3'b111, 3'b111, 1'b0, 1'b1);
        cycles(5); chk_o("lr_n40_off",  3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("lr_n41_HZ",   3'b111, 3'b111, 1'b0, 1'b1);
        cycles(6); chk_o("lr_n47_HZ",   3'b111, 3'b111, 1'b0, 1'b1);
        cyc();     chk_o("lr_n48_off",  3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("lr_n49_HZ",   3'b111, 3'b111, 1'b0, 1'b1);
        left_sw = 1'b0; right_sw = 1'b0;
        cycles(7); chk_o("lr_n56_off",  3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("lr_n57_idle", 3'b000, 3'b000, 1'b0, 1'b0);

        // Hazard during L2 aborts to idle at the step, then enters HZ next clk.
        left_sw = 1'b1;
        cycles(3); chk_o("abort_n60_L1",   3'b001, 3'b000, 1'b0, 1'b1);
        cycles(8); chk_o("abort_n68_L2",   3'b011, 3'b000, 1'b1, 1'b1);
        haz_sw = 1'b1; left_sw = 1'b0;
        cycles(7); chk_o("abort_n75_L2",   3'b011, 3'b000, 1'b0, 1'b1);
        cyc();     chk_o("abort_n76_idle", 3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("abort_n77_HZ",   3'b111, 3'b111, 1'b0, 1'b1);
        haz_sw = 1'b0;
        cycles(7); chk_o("abort_n84_off",  3'b000, 3'b000, 1'b1, 1'b0);
        cyc();     chk_o("abort_n85_idle", 3'b000, 3'b000, 1'b0, 1'b0);

        // Ten ticks with no request: nothing moves, counter stays at zero.
        for (int i = 0; i < 40; i++) begin
            cyc();
            chk_o("idle_ticks_out", 3'b000, 3'b000, 1'b0, 1'b0);
            chk("idle_ticks_cnt", 8'(dut.r_cnt), 8'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
